// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction prefetch front end.
package fetch_pkg;

  localparam int          WORD_BYTES   = 4;
  localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    DISCARD = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } fetch_entry_t;

  // Clears the byte-offset bits so every fetch address is word aligned.
  function automatic logic [31:0] word_align(input logic [31:0] a);
    return a & ~32'(WORD_BYTES - 1);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Circular buffer of fetched {inst, pc} entries with push, pop, flush and occupancy.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   push_i,
  input  fetch_entry_t           push_data_i,
  input  logic                   pop_i,
  input  logic                   flush_i,
  output fetch_entry_t           head_o,
  output logic                   valid_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int AW = $clog2(DEPTH);

  fetch_entry_t    mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [AW:0]     count_q, count_d;
  logic            do_pop;

  // Popping an empty queue is ignored; the caller reserves space before pushing.
  assign do_pop = pop_i && (count_q != '0);

  always_comb begin
    count_d = count_q;
    case ({push_i, do_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign valid_o = (count_q != '0);
  assign count_o = count_q;

endmodule

// File: rtl/imem_prefetch_queue.sv
// Fetch front end: one-outstanding-read handshake to instruction memory, a small
// queue of fetched words, and redirect handling that drops in-flight stale data.
module imem_prefetch_queue
  import fetch_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = DEF_RESET_PC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        deq_ready,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic [31:0] inst_pc4,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  localparam int             CW   = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0]  FULL = CW'(DEPTH);

  fetch_state_e  state_q;
  logic [31:0]   fetch_pc_q, mem_addr_q;
  logic          mem_req_q;

  logic          ack, push, pop;
  logic [CW-1:0] count, cnt_after;
  logic [31:0]   rpc, pc_nxt;
  fetch_entry_t  head, push_data;
  logic          head_vld;

  assign ack       = mem_ack && mem_req_q;
  assign push      = (state_q == WAIT) && ack && !redirect_valid;
  assign pop       = head_vld && deq_ready && !redirect_valid;
  assign cnt_after = count + CW'(push) - CW'(pop);
  assign rpc       = word_align(redirect_pc);
  assign pc_nxt    = fetch_pc_q + 32'(WORD_BYTES);
  assign push_data = '{inst: mem_rdata, pc: mem_addr_q};

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i       (clk),
    .rst_i       (reset),
    .push_i      (push),
    .push_data_i (push_data),
    .pop_i       (pop),
    .flush_i     (redirect_valid),
    .head_o      (head),
    .valid_o     (head_vld),
    .count_o     (count)
  );

  // In WAIT fetch_pc_q tracks the outstanding address; in DISCARD it holds the
  // redirect target while the old request drains.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      mem_req_q  <= 1'b0;
      mem_addr_q <= RESET_PC;
    end else begin
      case (state_q)
        IDLE: begin
          if (redirect_valid) begin
            fetch_pc_q <= rpc;
          end else if (count < FULL) begin
            mem_req_q  <= 1'b1;
            mem_addr_q <= fetch_pc_q;
            state_q    <= WAIT;
          end
        end
        WAIT: begin
          if (redirect_valid) begin
            fetch_pc_q <= rpc;
            if (ack) begin
              mem_req_q <= 1'b0;
              state_q   <= IDLE;
            end else begin
              state_q   <= DISCARD;
            end
          end else if (ack) begin
            fetch_pc_q <= pc_nxt;
            mem_addr_q <= pc_nxt;
            if (cnt_after >= FULL) begin
              mem_req_q <= 1'b0;
              state_q   <= IDLE;
            end
          end
        end
        DISCARD: begin
          if (redirect_valid) fetch_pc_q <= rpc;
          if (ack) begin
            mem_req_q <= 1'b0;
            state_q   <= IDLE;
          end
        end
        default: begin
          mem_req_q <= 1'b0;
          state_q   <= IDLE;
        end
      endcase
    end
  end

  assign mem_req    = mem_req_q;
  assign mem_addr   = mem_addr_q;
  assign inst_valid = head_vld;
  assign inst       = head_vld ? head.inst : 32'h0;
  assign inst_pc    = head_vld ? head.pc : 32'h0;
  assign inst_pc4   = head_vld ? head.pc + 32'(WORD_BYTES) : 32'h0;

endmodule

// File: tb/tb_imem_prefetch_queue.sv
// Directed bench for imem_prefetch_queue with a small latency-programmable memory model.
module tb_imem_prefetch_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        deq_ready;
  logic        inst_valid;
  logic [31:0] inst, inst_pc, inst_pc4;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  int n_chk  = 0;
  int n_fail = 0;
  int lat    = 0;
  int wcnt   = 0;

  imem_prefetch_queue #(.DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk            (clk),
    .reset          (reset),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .deq_ready      (deq_ready),
    .inst_valid     (inst_valid),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .inst_pc4       (inst_pc4),
    .mem_req        (mem_req),
    .mem_addr       (mem_addr),
    .mem_ack        (mem_ack),
    .mem_rdata      (mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Ack comes on the (lat+1)-th cycle a request is visible; data is {BEEF, addr[15:0]}.
  task automatic mem_model();
    if (reset || !mem_req) begin
      mem_ack = 1'b0;
      wcnt    = 0;
    end else if (wcnt >= lat) begin
      mem_ack   = 1'b1;
      mem_rdata = {16'hBEEF, mem_addr[15:0]};
      wcnt      = 0;
    end else begin
      mem_ack = 1'b0;
      wcnt++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    mem_model();
  endtask

  task automatic do_reset();
    reset          = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    deq_ready      = 1'b0;
    mem_ack        = 1'b0;
    wcnt           = 0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    mem_rdata = 32'h0;
    lat       = 0;
    do_reset();
    reset = 1'b1;
    chk("rst_valid", 32'(inst_valid), 32'd0);
    chk("rst_req",   32'(mem_req),    32'd0);
    chk("rst_addr",  mem_addr,        32'h0);
    chk("rst_inst",  inst,            32'h0);
    chk("rst_pc",    inst_pc,         32'h0);
    chk("rst_pc4",   inst_pc4,        32'h0);
    reset = 1'b0;

    // Zero-wait memory, always dequeuing: one word per cycle.
    deq_ready = 1'b1;
    tick();
    chk("zw_req0",   32'(mem_req),    32'd1);
    chk("zw_addr0",  mem_addr,        32'h0);
    chk("zw_nobyp",  32'(inst_valid), 32'd0);
    tick();
    chk("zw_pc0",    inst_pc,         32'h0);
    chk("zw_inst0",  inst,            32'hBEEF0000);
    chk("zw_pc4_0",  inst_pc4,        32'h4);
    for (int i = 1; i < 4; i++) begin
      tick();
      chk("zw_pc", inst_pc, 32'(4 * i));
    end

    // 3-cycle memory, no dequeue: fill to DEPTH then stop requesting.
    lat = 2;
    do_reset();
    tick();
    tick();
    chk("l3_hold_req",  32'(mem_req), 32'd1);
    chk("l3_hold_addr", mem_addr,     32'h0);
    for (int i = 0; i < 18; i++) tick();
    chk("full_req",   32'(mem_req),    32'd0);
    chk("full_valid", 32'(inst_valid), 32'd1);
    chk("full_head",  inst_pc,         32'h0);
    deq_ready = 1'b1;
    tick();
    deq_ready = 1'b0;
    chk("pop1_head",  inst_pc,         32'h4);
    chk("pop1_req",   32'(mem_req),    32'd0);
    tick();
    chk("refetch_req",  32'(mem_req), 32'd1);
    chk("refetch_addr", mem_addr,     32'h10);
    tick();
    tick();
    tick();
    chk("refull_req", 32'(mem_req), 32'd0);
    deq_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("drain_pc", inst_pc, 32'(8 + 4 * i));
    end

    // Redirect in the first cycle of a 3-cycle request; empty-queue dequeues ignored.
    lat = 2;
    do_reset();
    deq_ready = 1'b1;
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0103;
    tick();
    redirect_valid = 1'b0;
    chk("disc_req",  32'(mem_req), 32'd1);
    chk("disc_addr", mem_addr,     32'h0);
    tick();
    tick();
    chk("disc_drop_req",   32'(mem_req),    32'd0);
    chk("disc_drop_valid", 32'(inst_valid), 32'd0);
    tick();
    chk("redir_req",  32'(mem_req),    32'd1);
    chk("redir_addr", mem_addr,        32'h100);
    chk("redir_emp",  32'(inst_valid), 32'd0);
    tick();
    tick();
    tick();
    chk("redir_valid", 32'(inst_valid), 32'd1);
    chk("redir_pc",    inst_pc,         32'h100);
    chk("redir_inst",  inst,            32'hBEEF0100);
    chk("redir_pc4",   inst_pc4,        32'h104);

    // Redirect coinciding with ack: data dropped, queue flushed, no DISCARD.
    lat = 0;
    do_reset();
    tick();
    tick();
    tick();
    chk("ra_pre_valid", 32'(inst_valid), 32'd1);
    chk("ra_pre_addr",  mem_addr,        32'h8);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h200;
    tick();
    redirect_valid = 1'b0;
    chk("ra_flush", 32'(inst_valid), 32'd0);
    chk("ra_req0",  32'(mem_req),    32'd0);
    tick();
    chk("ra_req1",  32'(mem_req), 32'd1);
    chk("ra_addr",  mem_addr,     32'h200);
    tick();
    chk("ra_pc",    inst_pc,      32'h200);
    chk("ra_inst",  inst,         32'hBEEF0200);

    // Simultaneous push and pop at count=2 keeps occupancy and order.
    lat = 0;
    do_reset();
    tick();
    tick();
    tick();
    chk("pp_head0", inst_pc, 32'h0);
    deq_ready = 1'b1;
    tick();
    chk("pp_head1", inst_pc, 32'h4);
    tick();
    chk("pp_head2", inst_pc, 32'h8);
    lat = 100;
    tick();
    chk("pp_head3", inst_pc, 32'hC);
    tick();
    chk("pp_head4", inst_pc, 32'h10);
    tick();
    chk("pp_empty", 32'(inst_valid), 32'd0);

    // Reset asserted mid-WAIT takes effect without a clock edge.
    lat = 0;
    do_reset();
    tick();
    tick();
    lat = 2;
    tick();
    chk("mr_pre_valid", 32'(inst_valid), 32'd1);
    chk("mr_pre_addr",  mem_addr,        32'h8);
    reset = 1'b1;
    #1;
    chk("mr_req",   32'(mem_req),    32'd0);
    chk("mr_valid", 32'(inst_valid), 32'd0);
    chk("mr_addr",  mem_addr,        32'h0);
    tick();
    reset = 1'b0;
    tick();
    chk("mr_req1",  32'(mem_req), 32'd1);
    chk("mr_addr1", mem_addr,     32'h0);

    // Fetch PC and inst_pc4 wrap at the top of the address space.
    lat = 0;
    do_reset();
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFF;
    tick();
    redirect_valid = 1'b0;
    chk("wr_req0", 32'(mem_req), 32'd0);
    tick();
    chk("wr_addr", mem_addr, 32'hFFFF_FFFC);
    tick();
    chk("wr_pc",    inst_pc,  32'hFFFF_FFFC);
    chk("wr_pc4",   inst_pc4, 32'h0);
    chk("wr_inst",  inst,     32'hBEEFFFFC);
    chk("wr_naddr", mem_addr, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
